// File: rtl/pipe_stage_regs.sv
// PC, IF/ID and ID/EX pipeline registers of the 5-stage RV32I core, with per-stage stall/flush,
// valid tracking and saturating stall/bubble counters for CPI debug.
module pipe_stage_regs #(
    parameter int          XLEN     = 32,
    parameter int          CTRL_W   = 12,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallF,
    input  logic              StallD,
    input  logic              FlushD,
    input  logic              FlushE,
    input  logic [XLEN-1:0]   PCNextF,
    input  logic [31:0]       InstrF,
    input  logic [XLEN-1:0]   PCPlus4F,
    output logic [XLEN-1:0]   PCF,
    output logic [31:0]       InstrD,
    output logic [XLEN-1:0]   PCD,
    output logic [XLEN-1:0]   PCPlus4D,
    output logic              ValidD,
    input  logic [CTRL_W-1:0] CtrlD,
    input  logic [XLEN-1:0]   RD1D,
    input  logic [XLEN-1:0]   RD2D,
    input  logic [XLEN-1:0]   ImmExtD,
    input  logic [4:0]        Rs1D,
    input  logic [4:0]        Rs2D,
    input  logic [4:0]        RdD,
    output logic [CTRL_W-1:0] CtrlE,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   ImmExtE,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [4:0]        Rs1E,
    output logic [4:0]        Rs2E,
    output logic [4:0]        RdE,
    output logic              ValidE,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  BubbleCnt
);

    localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [XLEN-1:0]   r_pcf;
    logic [31:0]       r_instr_d;
    logic [XLEN-1:0]   r_pc_d;
    logic [XLEN-1:0]   r_pc_plus4_d;
    logic              r_valid_d;
    logic [CTRL_W-1:0] r_ctrl_e;
    logic [XLEN-1:0]   r_rd1_e;
    logic [XLEN-1:0]   r_rd2_e;
    logic [XLEN-1:0]   r_imm_e;
    logic [XLEN-1:0]   r_pc_e;
    logic [XLEN-1:0]   r_pc_plus4_e;
    logic [4:0]        r_rs1_e;
    logic [4:0]        r_rs2_e;
    logic [4:0]        r_rd_e;
    logic              r_valid_e;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_bubble_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcf <= XLEN'(RESET_PC);
        end else if (!StallF) begin
            r_pcf <= PCNextF;
        end
    end

    // IF/ID: flush beats stall, so a taken branch squashes even a held instruction.
    always_ff @(posedge clk) begin
        if (reset || FlushD) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid_d    <= 1'b0;
        end else if (!StallD) begin
            r_instr_d    <= InstrF;
            r_pc_d       <= r_pcf;
            r_pc_plus4_d <= PCPlus4F;
            r_valid_d    <= 1'b1;
        end
    end

    // ID/EX: a bubble clears CtrlE[0] and RdE so the hazard unit never matches on it.
    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            r_ctrl_e     <= '0;
            r_rd1_e      <= '0;
            r_rd2_e      <= '0;
            r_imm_e      <= '0;
            r_pc_e       <= '0;
            r_pc_plus4_e <= '0;
            r_rs1_e      <= '0;
            r_rs2_e      <= '0;
            r_rd_e       <= '0;
            r_valid_e    <= 1'b0;
        end else begin
            r_ctrl_e     <= CtrlD;
            r_rd1_e      <= RD1D;
            r_rd2_e      <= RD2D;
            r_imm_e      <= ImmExtD;
            r_pc_e       <= r_pc_d;
            r_pc_plus4_e <= r_pc_plus4_d;
            r_rs1_e      <= Rs1D;
            r_rs2_e      <= Rs2D;
            r_rd_e       <= RdD;
            r_valid_e    <= r_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (StallD && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (FlushE && (r_bubble_cnt != CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign PCF       = r_pcf;
    assign InstrD    = r_instr_d;
    assign PCD       = r_pc_d;
    assign PCPlus4D  = r_pc_plus4_d;
    assign ValidD    = r_valid_d;
    assign CtrlE     = r_ctrl_e;
    assign RD1E      = r_rd1_e;
    assign RD2E      = r_rd2_e;
    assign ImmExtE   = r_imm_e;
    assign PCE       = r_pc_e;
    assign PCPlus4E  = r_pc_plus4_e;
    assign Rs1E      = r_rs1_e;
    assign Rs2E      = r_rs2_e;
    assign RdE       = r_rd_e;
    assign ValidE    = r_valid_e;
    assign StallCnt  = r_stall_cnt;
    assign BubbleCnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed bench for pipe_stage_regs: reset, free run, load-use, branch, flush-vs-stall and
// counter saturation with hand-computed expectations (CNT_W=4).
module tb_pipe_stage_regs;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 12;
    localparam int CNT_W  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              reset;
    logic              StallF, StallD, FlushD, FlushE;
    logic [XLEN-1:0]   PCNextF, PCPlus4F;
    logic [31:0]       InstrF;
    logic [XLEN-1:0]   PCF, PCD, PCPlus4D;
    logic [31:0]       InstrD;
    logic              ValidD;
    logic [CTRL_W-1:0] CtrlD, CtrlE;
    logic [XLEN-1:0]   RD1D, RD2D, ImmExtD;
    logic [4:0]        Rs1D, Rs2D, RdD;
    logic [XLEN-1:0]   RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]        Rs1E, Rs2E, RdE;
    logic              ValidE;
    logic [CNT_W-1:0]  StallCnt, BubbleCnt;

    int n_cmp = 0;
    int n_err = 0;

    pipe_stage_regs #(
        .XLEN(XLEN), .CTRL_W(CTRL_W), .RESET_PC(32'h0000_0000), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .PCNextF(PCNextF), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
        .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .CtrlD(CtrlD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .CtrlE(CtrlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ValidE(ValidE), .StallCnt(StallCnt), .BubbleCnt(BubbleCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        if (observed !== expected) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Inputs are changed 1 time unit after the edge; outputs are sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc_next, input logic [31:0] instr, input logic [31:0] pc4);
        PCNextF  = pc_next;
        InstrF   = instr;
        PCPlus4F = pc4;
    endtask

    initial begin
        reset  = 1'b1;
        StallF = 1'b0; StallD = 1'b1; FlushD = 1'b0; FlushE = 1'b1;  // ignored during reset
        fetch(32'h40, 32'hDEAD_BEEF, 32'h44);
        CtrlD = 12'hFFF; RD1D = 32'h1111_1111; RD2D = 32'h2222_2222; ImmExtD = 32'h3333_3333;
        Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd7;
        #1;

        // Reset
        step(); step();
        check("rst_pcf",    PCF,       32'h0);
        check("rst_instrd", InstrD,    NOP);
        check("rst_validd", 32'(ValidD), 32'd0);
        check("rst_valide", 32'(ValidE), 32'd0);
        check("rst_ctrle",  32'(CtrlE),  32'd0);
        check("rst_stall",  32'(StallCnt),  32'd0);
        check("rst_bubble", 32'(BubbleCnt), 32'd0);

        // Free run
        reset = 1'b0; StallD = 1'b0; FlushE = 1'b0;
        fetch(32'd4, 32'h0010_0093, 32'd4);
        CtrlD = 12'h010; RdD = 5'd1;
        step();
        check("run1_pcf",    PCF,    32'd4);
        check("run1_instrd", InstrD, 32'h0010_0093);
        check("run1_validd", 32'(ValidD), 32'd1);
        check("run1_valide", 32'(ValidE), 32'd0);
        fetch(32'd8, 32'h0020_0113, 32'd8);
        CtrlD = 12'h0A5; RdD = 5'd3;
        step();
        check("run2_pcf",    PCF,    32'd8);
        check("run2_pcd",    PCD,    32'd4);
        check("run2_ctrle",  32'(CtrlE), 32'h0A5);
        check("run2_rde",    32'(RdE),   32'd3);
        check("run2_rd1e",   RD1E,   32'h1111_1111);
        check("run2_valide", 32'(ValidE), 32'd1);
        fetch(32'd12, 32'h0030_0193, 32'd12);
        step();
        check("run3_pcf",   PCF,      32'd12);
        check("run3_pce",   PCE,      32'd4);
        check("run3_pc4e",  PCPlus4E, 32'd8);
        check("run3_pc4d",  PCPlus4D, 32'd12);
        fetch(32'h10, 32'h0000_2203, 32'd16);
        step();
        check("run4_pcf",   PCF,    32'h10);
        check("run4_instrd", InstrD, 32'h0000_2203);

        // Load-use
        StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1;
        fetch(32'h14, 32'h0042_8293, 32'h14);
        CtrlD = 12'h001; RdD = 5'd5;
        step();
        check("lu_pcf",    PCF,    32'h10);
        check("lu_instrd", InstrD, 32'h0000_2203);
        check("lu_pcd",    PCD,    32'd12);
        check("lu_valide", 32'(ValidE), 32'd0);
        check("lu_rde",    32'(RdE),    32'd0);
        check("lu_ctrle",  32'(CtrlE),  32'd0);
        check("lu_stall",  32'(StallCnt),  32'd1);
        check("lu_bubble", 32'(BubbleCnt), 32'd1);
        StallF = 1'b0; StallD = 1'b0; FlushE = 1'b0;
        CtrlD = 12'h7F0; RdD = 5'd6;
        step();
        check("lu2_pcf",    PCF,    32'h14);
        check("lu2_pce",    PCE,    32'd12);
        check("lu2_valide", 32'(ValidE), 32'd1);
        check("lu2_rde",    32'(RdE),    32'd6);
        check("lu2_instrd", InstrD, 32'h0042_8293);
        check("lu2_stall",  32'(StallCnt), 32'd1);

        // Branch
        FlushD = 1'b1; FlushE = 1'b1;
        fetch(32'h80, 32'h0000_006F, 32'h18);
        step();
        check("br_pcf",    PCF,    32'h80);
        check("br_instrd", InstrD, NOP);
        check("br_pcd",    PCD,    32'd0);
        check("br_validd", 32'(ValidD), 32'd0);
        check("br_valide", 32'(ValidE), 32'd0);
        check("br_bubble", 32'(BubbleCnt), 32'd2);
        FlushD = 1'b0; FlushE = 1'b0;
        fetch(32'h84, 32'h0050_0313, 32'h84);
        step();
        check("br2_instrd", InstrD, 32'h0050_0313);
        check("br2_pcd",    PCD,    32'h80);
        check("br2_validd", 32'(ValidD), 32'd1);
        check("br2_valide", 32'(ValidE), 32'd0);

        // Flush wins over stall on IF/ID
        StallF = 1'b1; StallD = 1'b1; FlushD = 1'b1;
        fetch(32'h88, 32'h0060_0393, 32'h88);
        step();
        check("fs_instrd", InstrD, NOP);
        check("fs_validd", 32'(ValidD), 32'd0);
        check("fs_pcd",    PCD,    32'd0);
        check("fs_pcf",    PCF,    32'h84);
        check("fs_valide", 32'(ValidE), 32'd1);
        check("fs_stall",  32'(StallCnt), 32'd2);

        // Saturation: 2 stalls so far, 13 more reach 15, then it must hold
        FlushD = 1'b0;
        for (int i = 0; i < 13; i++) step();
        check("sat_reach", 32'(StallCnt), 32'd15);
        check("sat_hold_instr", InstrD, NOP);
        for (int i = 0; i < 7; i++) step();
        check("sat_stay",  32'(StallCnt), 32'd15);
        check("sat_pcf",   PCF, 32'h84);

        // Reset mid-stall clears everything
        reset = 1'b1;
        step();
        check("rst2_stall",  32'(StallCnt),  32'd0);
        check("rst2_bubble", 32'(BubbleCnt), 32'd0);
        check("rst2_pcf",    PCF, 32'h0);
        check("rst2_instrd", InstrD, NOP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
